// File: rtl/sensor_input_conditioner.sv
// Input front end: two-flop synchroniser, per-channel debounce, rising-edge pulses,
// sticky event flags and a priority-encoded event code for the alarm FSM and display.
module sensor_input_conditioner #(
  parameter int N_CH       = 5,
  parameter int DEB_CYCLES = 16,
  parameter int CNT_W      = 20
) (
  input  logic            clk1,
  input  logic            reset,
  input  logic [N_CH-1:0] sens_raw,
  input  logic [N_CH-1:0] evt_clr,
  output logic [N_CH-1:0] sens_clean,
  output logic [N_CH-1:0] sens_rise,
  output logic [N_CH-1:0] evt_latched,
  output logic            evt_any,
  output logic [2:0]      evt_code
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic [N_CH-1:0]  sync1_q, sync2_q;
  logic [N_CH-1:0]  clean_q, clean_d;
  logic [N_CH-1:0]  rise_q, rise_d;
  logic [N_CH-1:0]  evt_q, evt_d;
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];

  always_ff @(posedge clk1 or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sens_raw;
      sync2_q <= sync1_q;
    end
  end

  // A new level is accepted only after sync2 has disagreed with the clean level
  // for DEB_CYCLES consecutive edges; any agreement restarts the count.
  always_comb begin
    clean_d = clean_q;
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == clean_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        clean_d[i] = sync2_q[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    rise_d = clean_d & ~clean_q;
    evt_d  = (evt_q & ~evt_clr) | rise_q;
  end

  always_ff @(posedge clk1 or negedge reset) begin
    if (!reset) begin
      clean_q <= '0;
      rise_q  <= '0;
      evt_q   <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      clean_q <= clean_d;
      rise_q  <= rise_d;
      evt_q   <= evt_d;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Scan from the highest index down so the lowest latched channel wins.
  always_comb begin
    evt_code = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (evt_q[i]) begin
        evt_code = 3'(i + 1);
      end
    end
  end

  assign sens_clean  = clean_q;
  assign sens_rise   = rise_q;
  assign evt_latched = evt_q;
  assign evt_any     = |evt_q;

endmodule
